// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register.
// Holds the operation-mode encoding used by the top and every stage.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_FWD  = 2'b01,
    MODE_REV  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  function automatic logic is_shift(
    input mode_t m
  );
    return (m == MODE_FWD) ||
           (m == MODE_REV);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One WIDTH-bit stage of the universal shift register.
// Ports: clk, rst_n (sync, active-low), i_sel (4-way next-value
// select: hold / fwd neighbour / rev neighbour / load),
// i_fwd, i_rev, i_load candidate values, o_q registered value.
module shift_stage
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       i_sel,
  input  logic [WIDTH-1:0] i_fwd,
  input  logic [WIDTH-1:0] i_rev,
  input  logic [WIDTH-1:0] i_load,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_nxt;
  mode_t            w_sel;

  assign w_sel = mode_t'(i_sel);

  always_comb begin
    w_nxt = r_q;
    unique case (w_sel)
      MODE_HOLD: w_nxt = r_q;
      MODE_FWD:  w_nxt = i_fwd;
      MODE_REV:  w_nxt = i_rev;
      MODE_LOAD: w_nxt = i_load;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_nxt;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/univ_shift_register.sv
// Universal shift register: DEPTH stages of WIDTH bits with
// hold / shift-forward / shift-reverse / parallel load.
// Ports: clk, rst_n (sync, active-low), mode, S_in, D, rot
// (only with SHIFT_REG_ROTATE_EN), Q, S_out_fwd, S_out_rev,
// fill_cnt, full. All outputs come straight from registers.
// Option: define SHIFT_REG_ROTATE_EN to add the rot port.
module univ_shift_register
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       S_in,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic                   rot,
`endif
  input  logic [DEPTH*WIDTH-1:0] D,
  output logic [DEPTH*WIDTH-1:0] Q,
  output logic [WIDTH-1:0]       S_out_fwd,
  output logic [WIDTH-1:0]       S_out_rev,
  output logic [CW-1:0]          fill_cnt,
  output logic                   full
);

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  mode_t            w_mode;
  logic             w_rot;
  logic [WIDTH-1:0] w_fwd_in;
  logic [WIDTH-1:0] w_rev_in;
  logic [WIDTH-1:0] w_stage [DEPTH];
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_full;

  assign w_mode = mode_t'(mode);

`ifdef SHIFT_REG_ROTATE_EN
  assign w_rot = rot;
`else
  assign w_rot = 1'b0;
`endif

  // Entry values for each direction; a rotate
  // recirculates the stage that is about to leave.
  assign w_fwd_in = w_rot ? w_stage[DEPTH-1] : S_in;
  assign w_rev_in = w_rot ? w_stage[0] : S_in;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] w_fwd_nb;
    logic [WIDTH-1:0] w_rev_nb;

    if (k == 0) begin : g_fwd_entry
      assign w_fwd_nb = w_fwd_in;
    end else begin : g_fwd_chain
      assign w_fwd_nb = w_stage[k-1];
    end

    if (k == DEPTH - 1) begin : g_rev_entry
      assign w_rev_nb = w_rev_in;
    end else begin : g_rev_chain
      assign w_rev_nb = w_stage[k+1];
    end

    shift_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_sel  (mode),
      .i_fwd  (w_fwd_nb),
      .i_rev  (w_rev_nb),
      .i_load (D[k*WIDTH +: WIDTH]),
      .o_q    (w_stage[k])
    );

    assign Q[k*WIDTH +: WIDTH] = w_stage[k];
  end

  // Fill count: saturating on plain shifts, unchanged
  // on a rotate, forced to DEPTH on a load.
  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case (w_mode)
      MODE_HOLD: begin
        w_cnt_nxt = r_cnt;
      end
      MODE_FWD,
      MODE_REV: begin
        if (!w_rot && (r_cnt != CNT_FULL)) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      MODE_LOAD: begin
        w_cnt_nxt = CNT_FULL;
      end
    endcase
  end

  // full is registered from the next count so it
  // stays a pure register output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_full <= (w_cnt_nxt == CNT_FULL);
    end
  end

  assign S_out_fwd = w_stage[DEPTH-1];
  assign S_out_rev = w_stage[0];
  assign fill_cnt  = r_cnt;
  assign full      = r_full;

endmodule
